// File: rtl/bsg_credit_returner.sv
// Receiver-side credit returner: batches freed slots and returns them as tokens of up to max_step_p per cycle.
// Moore outputs, one cycle behind consume_i; ready_i=0 holds the token and it never shrinks, pending keeps growing.
module bsg_credit_returner #(
   parameter int max_step_p = 2,
   parameter int max_val_p  = 100000,
   parameter int batch_p    = 4,
   parameter int timeout_p  = 8,
   localparam int ptr_width_lp  = $clog2(max_val_p+1),
   localparam int step_width_lp = $clog2(max_step_p+1),
   localparam int tmr_width_lp  = $clog2(timeout_p+1)
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [step_width_lp-1:0] consume_i,
   output logic                     credit_v_o,
   output logic [step_width_lp-1:0] credit_o,
   input  logic                     ready_i,
   output logic [ptr_width_lp-1:0]  pending_o,
   output logic                     overflow_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SEND  = 2'd2
   } state_e;

   state_e                    state, state_n;
   logic [ptr_width_lp-1:0]   pending, pn;
   logic [tmr_width_lp-1:0]   timer, timer_n;
   logic [ptr_width_lp:0]     sum;
   logic [step_width_lp-1:0]  ret;
   logic                      sat;
   logic                      at_batch;

   assign credit_v_o = (state == SEND);
   assign credit_o   = !credit_v_o ? '0
                     : (pending >= ptr_width_lp'(max_step_p)) ? step_width_lp'(max_step_p)
                     : pending[step_width_lp-1:0];
   assign pending_o  = pending;

   // ret never exceeds pending, so the one-bit-wider sum cannot wrap below zero
   assign ret = (credit_v_o && ready_i) ? credit_o : '0;
   assign sum = {1'b0, pending} + (ptr_width_lp+1)'(consume_i) - (ptr_width_lp+1)'(ret);
   assign sat = (sum > (ptr_width_lp+1)'(max_val_p));
   assign pn  = sat ? ptr_width_lp'(max_val_p) : sum[ptr_width_lp-1:0];
   assign at_batch = (32'(pn) >= batch_p);

   always_comb begin
      state_n = state;
      timer_n = timer;
      case (state)
         IDLE: begin
            if (pn == '0)
               state_n = IDLE;
            else if (at_batch)
               state_n = SEND;
            else begin
               state_n = ACCUM;
               timer_n = '0;
            end
         end
         ACCUM: begin
            // timer runs from entry, not from the last consume, so hold time is bounded
            if (at_batch || (timer == tmr_width_lp'(timeout_p-1)))
               state_n = SEND;
            else
               timer_n = timer + 1'b1;
         end
         SEND: begin
            if (pn == '0)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state      <= IDLE;
         pending    <= '0;
         timer      <= '0;
         overflow_o <= 1'b0;
      end else begin
         state   <= state_n;
         pending <= pn;
         timer   <= timer_n;
         if (sat)
            overflow_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bsg_credit_returner.sv
// Scoreboard bench for bsg_credit_returner: a behavioural model queues the expected outputs for each driven cycle.
module tb_bsg_credit_returner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  consume;
   logic        ready;
   logic        credit_v;
   logic [1:0]  credit;
   logic [16:0] pending;
   logic        overflow;

   logic        rst2_n;
   logic [1:0]  consume2;
   logic        ready2;
   logic        credit_v2;
   logic [1:0]  credit2;
   logic [2:0]  pending2;
   logic        overflow2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bsg_credit_returner dut (
      .clk_i(clk), .reset_n_i(rst_n), .consume_i(consume),
      .credit_v_o(credit_v), .credit_o(credit), .ready_i(ready),
      .pending_o(pending), .overflow_o(overflow)
   );

   bsg_credit_returner #(.max_step_p(2), .max_val_p(7), .batch_p(8), .timeout_p(100)) dut_small (
      .clk_i(clk), .reset_n_i(rst2_n), .consume_i(consume2),
      .credit_v_o(credit_v2), .credit_o(credit2), .ready_i(ready2),
      .pending_o(pending2), .overflow_o(overflow2)
   );

   always @(posedge clk) begin
      if (rst_n === 1'b1)
         assert (consume <= 2'd2) else $error("illegal consume_i %0d", consume);
   end

   typedef struct packed {
      logic        v;
      logic [1:0]  c;
      logic [16:0] p;
      logic        ovf;
   } exp_t;

   exp_t sb_q[$];

   // model state: 0 idle, 1 accumulating, 2 sending
   int m_st = 0, m_p = 0, m_t = 0, m_ovf = 0;
   int tot_c = 0, tot_r = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step(input logic [1:0] c, input logic r, input logic rn);
      int   mv, mc, mret, s;
      exp_t e;
      @(negedge clk);
      consume = c;
      ready   = r;
      rst_n   = rn;
      if (!rn) begin
         m_st = 0; m_p = 0; m_t = 0; m_ovf = 0;
         tot_c = 0; tot_r = 0;
      end else begin
         if (credit_v && r) tot_r += int'(credit);
         tot_c += int'(c);
         mv   = (m_st == 2) ? 1 : 0;
         mc   = mv ? ((m_p >= 2) ? 2 : m_p) : 0;
         mret = (mv && r) ? mc : 0;
         s    = m_p + int'(c) - mret;
         if (s > 100000) begin
            s = 100000;
            m_ovf = 1;
         end
         if (m_st == 0) begin
            if (s >= 4) m_st = 2;
            else if (s > 0) begin m_st = 1; m_t = 0; end
         end else if (m_st == 1) begin
            if (s >= 4 || m_t == 7) m_st = 2;
            else m_t++;
         end else begin
            if (s == 0) m_st = 0;
         end
         m_p = s;
      end
      e.v   = (m_st == 2);
      e.c   = (m_st == 2) ? ((m_p >= 2) ? 2'd2 : 2'(m_p)) : 2'd0;
      e.p   = 17'(m_p);
      e.ovf = (m_ovf != 0);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("sb_credit_v", 32'(credit_v), 32'(e.v));
      check("sb_credit", 32'(credit), 32'(e.c));
      check("sb_pending", 32'(pending), 32'(e.p));
      check("sb_overflow", 32'(overflow), 32'(e.ovf));
      if (!overflow)
         check("conservation", 32'(tot_c), 32'(tot_r + int'(pending)));
   endtask

   task automatic step2(input logic [1:0] c, input logic rn);
      @(negedge clk);
      consume2 = c;
      ready2   = 1'b0;
      rst2_n   = rn;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; consume = '0; ready = 1'b0;
      rst2_n = 1'b0; consume2 = '0; ready2 = 1'b0;

      // reset ignores inputs
      step(2, 1, 0);
      step(2, 1, 0);
      check("rst_pending", 32'(pending), 0);
      check("rst_credit_v", 32'(credit_v), 0);
      check("rst_credit", 32'(credit), 0);
      check("rst_overflow", 32'(overflow), 0);
      step(0, 1, 1);
      check("post_rst_pending", 32'(pending), 0);
      check("post_rst_credit_v", 32'(credit_v), 0);
      step(0, 1, 1);

      // batch trigger
      step(2, 1, 1);
      check("batch_c1_pending", 32'(pending), 2);
      check("batch_c1_v", 32'(credit_v), 0);
      step(2, 1, 1);
      check("batch_c2_v", 32'(credit_v), 1);
      check("batch_c2_credit", 32'(credit), 2);
      step(0, 1, 1);
      check("batch_c3_v", 32'(credit_v), 1);
      check("batch_c3_credit", 32'(credit), 2);
      step(0, 1, 1);
      check("batch_c4_pending", 32'(pending), 0);
      check("batch_c4_v", 32'(credit_v), 0);

      // idle timeout forces a return of a single credit
      step(1, 1, 1);
      for (int i = 1; i <= 8; i++) begin
         check("timeout_hold_v", 32'(credit_v), 0);
         step(0, 1, 1);
      end
      check("timeout_v", 32'(credit_v), 1);
      check("timeout_credit", 32'(credit), 1);
      step(0, 1, 1);
      check("timeout_drained", 32'(pending), 0);

      // backpressure: token held, pending grows
      step(2, 0, 1);
      step(2, 0, 1);
      check("bp_enter_v", 32'(credit_v), 1);
      step(1, 0, 1);
      check("bp_pending5", 32'(pending), 5);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 1);
         check("bp_hold_v", 32'(credit_v), 1);
         check("bp_hold_credit", 32'(credit), 2);
      end
      check("bp_pending8", 32'(pending), 8);
      for (int i = 0; i < 4; i++) begin
         check("bp_drain_v", 32'(credit_v), 1);
         check("bp_drain_credit", 32'(credit), 2);
         step(0, 1, 1);
      end
      check("bp_idle_v", 32'(credit_v), 0);
      check("bp_idle_pending", 32'(pending), 0);

      // simultaneous consume and return
      step(2, 1, 1);
      step(2, 0, 1);
      step(1, 1, 1);
      check("sim_pending3", 32'(pending), 3);
      step(2, 1, 1);
      check("sim_pending_after", 32'(pending), 3);
      check("sim_credit", 32'(credit), 2);
      step(0, 1, 1);
      check("sim_tail_credit", 32'(credit), 1);
      step(0, 1, 1);
      check("sim_idle_v", 32'(credit_v), 0);
      check("sim_idle_pending", 32'(pending), 0);

      // saturation on a small instance, then reset mid-operation
      step2(0, 0);
      step2(2, 1);
      step2(2, 1);
      step2(2, 1);
      check("ovf_pending6", 32'(pending2), 6);
      check("ovf_flag_clear", 32'(overflow2), 0);
      step2(2, 1);
      check("ovf_pending_sat", 32'(pending2), 7);
      check("ovf_flag_set", 32'(overflow2), 1);
      step2(0, 1);
      check("ovf_sticky", 32'(overflow2), 1);
      check("ovf_no_send", 32'(credit_v2), 0);
      step2(0, 0);
      check("ovf_rst_pending", 32'(pending2), 0);
      check("ovf_rst_flag", 32'(overflow2), 0);
      check("ovf_rst_v", 32'(credit_v2), 0);

      // random traffic against the model, with occasional resets
      for (int i = 0; i < 400; i++) begin
         step(2'($urandom_range(0, 2)), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 99) != 0));
      end
      for (int i = 0; i < 20; i++)
         step(0, 1, 1);
      check("final_pending", 32'(pending), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
